// File: rtl/drsstc_interrupter_prog.sv
// Programmable DRSSTC interrupter: gates the synchronised resonant feedback into
// whole-cycle bursts (time-window or gen-cycle-count) with a hard max-on-time clamp.
module drsstc_interrupter_prog #(
    parameter int CLK_MHZ   = 100,
    parameter int CNT_W     = 24,
    parameter int CYC_W     = 8,
    parameter int MAX_ON_US = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] on_time,
    input  logic [CYC_W-1:0] cycles,
    input  logic             gen,
    output logic             out,
    output logic             active,
    output logic             fault
);
    localparam int MAX_ON_CLK = CLK_MHZ * MAX_ON_US;
    localparam logic [CNT_W-1:0] CLAMP_AT = CNT_W'(MAX_ON_CLK - 1);

    logic             gen_m, gen_s, gen_d;
    logic             en_q;
    logic [CNT_W-1:0] pcnt, oncnt;
    logic [CNT_W-1:0] period_sh, on_time_sh, win_len;
    logic [CYC_W-1:0] cycles_sh, rem;
    logic             mode_sh;
    logic             gate, lock, fault_q;
    logic             gen_rise, start, run, win, clamp, gate_set;

    assign gen_rise = gen_s & ~gen_d;
    // A new period starts on en rising, at the counter wrap, or continuously while
    // the latched period is 0 so that a later non-zero period is picked up.
    assign start    = en & (~en_q | (period_sh == '0) | (pcnt == period_sh - CNT_W'(1)));
    // The en-rise cycle still holds stale shadows, so no gating decision is made in it.
    assign run      = en & en_q & (period_sh != '0);
    assign win_len  = (on_time_sh < period_sh) ? on_time_sh : period_sh;
    assign win      = run & (mode_sh ? (rem != '0) : (pcnt < win_len));
    assign clamp    = gate & (oncnt == CLAMP_AT);
    assign gate_set = gen_rise & win & ~lock & ~clamp;

    assign out    = gate & gen_d;
    assign active = gate;
    assign fault  = fault_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            gen_m      <= 1'b0;
            gen_s      <= 1'b0;
            gen_d      <= 1'b0;
            en_q       <= 1'b0;
            pcnt       <= '0;
            oncnt      <= '0;
            period_sh  <= '0;
            on_time_sh <= '0;
            cycles_sh  <= '0;
            mode_sh    <= 1'b0;
            rem        <= '0;
            gate       <= 1'b0;
            lock       <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            gen_m <= gen;
            gen_s <= gen_m;
            gen_d <= gen_s;
            en_q  <= en;

            if (start) begin
                period_sh  <= period;
                on_time_sh <= on_time;
                cycles_sh  <= cycles;
                mode_sh    <= mode;
            end

            if (!en || (period_sh == '0) || start) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + CNT_W'(1);
            end

            // Gate only changes on a gen rising edge (gen_d low), except for the clamp.
            if (clamp) begin
                gate <= 1'b0;
            end else if (gen_rise) begin
                gate <= gate_set;
            end

            oncnt <= (gate && !clamp) ? oncnt + CNT_W'(1) : '0;

            if (start) begin
                lock    <= 1'b0;
                fault_q <= 1'b0;
            end else if (clamp) begin
                lock    <= 1'b1;
                fault_q <= 1'b1;
            end

            if (start) begin
                rem <= cycles;
            end else if (!en) begin
                rem <= '0;
            end else if (gate_set && mode_sh) begin
                rem <= rem - CYC_W'(1);
            end
        end
    end

    logic unused_cycles_sh;
    assign unused_cycles_sh = ^cycles_sh;
endmodule

// File: tb/tb_drsstc_interrupter_prog.sv
// Directed bench for drsstc_interrupter_prog: a 200 us-limit instance for gating
// behaviour and a 1 us-limit instance (MAX_ON_CLK=100) for the clamp.
module tb_drsstc_interrupter_prog;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        mode = 1'b0;
    logic        gen = 1'b0;
    logic [23:0] period = '0;
    logic [23:0] on_time = '0;
    logic [7:0]  cycles = '0;
    logic        out, active, fault;
    logic        out_c, active_c, fault_c;

    int checks = 0;
    int errors = 0;
    int tcount = 0;
    int gph = 0;
    int last_gen_rise = -100;
    bit gen_run = 1'b0;
    int rises = 0;
    int bad_w = 0;
    int bad_lat = 0;
    int wcur = 0;
    logic out_prev = 1'b0;

    drsstc_interrupter_prog #(.CLK_MHZ(100), .CNT_W(24), .CYC_W(8), .MAX_ON_US(200)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .period(period), .on_time(on_time),
        .cycles(cycles), .gen(gen), .out(out), .active(active), .fault(fault));

    drsstc_interrupter_prog #(.CLK_MHZ(100), .CNT_W(24), .CYC_W(8), .MAX_ON_US(1)) dut_c (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .period(period), .on_time(on_time),
        .cycles(cycles), .gen(gen), .out(out_c), .active(active_c), .fault(fault_c));

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached, got no end, need $finish");
        $fatal(1, "watchdog");
    end

    // Sample on the falling edge, then drive gen (5 high / 5 low) for the next cycle.
    task automatic tick();
        bit g;
        @(negedge clk);
        tcount++;
        if (out && !out_prev) begin
            rises++;
            if (tcount - last_gen_rise != 3) bad_lat++;
            wcur = 1;
        end else if (out) begin
            wcur++;
        end else if (out_prev) begin
            if (wcur != 5) bad_w++;
        end
        out_prev = out;
        if (gen_run) begin
            g = (gph < 5);
            if (g && !gen) last_gen_rise = tcount;
            gen = g;
            gph = (gph + 1) % 10;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        en = 1'b0;
        gen_run = 1'b0;
        gen = 1'b0;
        gph = 0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rises = 0; bad_w = 0; bad_lat = 0; wcur = 0;
    endtask

    task automatic setup_window(input logic [23:0] p, input logic [23:0] ot);
        mode = 1'b0;
        period = p;
        on_time = ot;
        gen_run = 1'b1;
        en = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out !== 1'b0) begin errors++; $display("FAIL reset_out: got %b need 0", out); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b need 0", active); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b need 0", fault); end
        checks++; if (dut.pcnt !== 24'd0) begin errors++; $display("FAIL reset_pcnt: got %0d need 0", dut.pcnt); end
        checks++; if (fault_c !== 1'b0) begin errors++; $display("FAIL reset_fault_c: got %b need 0", fault_c); end
    endtask

    task automatic test_window_mode();
        int late, fseen;
        do_reset();
        setup_window(24'd1000, 24'd300);
        for (int p = 0; p < 2; p++) begin
            rises = 0; bad_w = 0; bad_lat = 0; late = 0; fseen = 0;
            for (int i = 0; i < 1000; i++) begin
                tick();
                if (i >= 305 && out) late++;
                if (fault) fseen++;
            end
            checks++; if (rises != 30) begin errors++; $display("FAIL win_count p%0d: got %0d need 30", p, rises); end
            checks++; if (bad_w != 0) begin errors++; $display("FAIL win_width p%0d: got %0d bad need 0", p, bad_w); end
            checks++; if (bad_lat != 0) begin errors++; $display("FAIL win_latency p%0d: got %0d bad need 0", p, bad_lat); end
            checks++; if (late != 0) begin errors++; $display("FAIL win_quiet p%0d: got %0d high need 0", p, late); end
            checks++; if (fseen != 0) begin errors++; $display("FAIL win_fault p%0d: got %0d need 0", p, fseen); end
        end
    endtask

    task automatic test_cycle_mode();
        do_reset();
        mode = 1'b1;
        period = 24'd1000;
        cycles = 8'd4;
        gen_run = 1'b1;
        en = 1'b1;
        for (int p = 0; p < 2; p++) begin
            rises = 0; bad_w = 0;
            for (int i = 0; i < 1000; i++) begin
                tick();
                if (i == 100 || i == 999) begin
                    checks++;
                    if (active !== 1'b0) begin errors++; $display("FAIL cyc_active p%0d i%0d: got %b need 0", p, i, active); end
                end
            end
            checks++; if (rises != 4) begin errors++; $display("FAIL cyc_count p%0d: got %0d need 4", p, rises); end
            checks++; if (bad_w != 0) begin errors++; $display("FAIL cyc_width p%0d: got %0d bad need 0", p, bad_w); end
        end
    endtask

    task automatic test_clamp();
        int r, f, nofault, crises;
        logic cprev;
        do_reset();
        setup_window(24'd1000, 24'd300);
        r = -1; f = -1; nofault = 0; crises = 0; cprev = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (active_c && r < 0) r = i;
            if (!active_c && r >= 0 && f < 0) f = i;
            if (f >= 0 && !fault_c) nofault++;
            if (f >= 0 && out_c && !cprev) crises++;
            cprev = out_c;
        end
        checks++; if (r < 0 || f - r != 100) begin errors++; $display("FAIL clamp_len: got %0d need 100", f - r); end
        checks++; if (nofault != 0) begin errors++; $display("FAIL clamp_fault_sticky: got %0d low need 0", nofault); end
        checks++; if (crises != 0) begin errors++; $display("FAIL clamp_no_pulses: got %0d need 0", crises); end
        tick();
        checks++; if (fault_c !== 1'b0) begin errors++; $display("FAIL clamp_fault_clear: got %b need 0", fault_c); end
    endtask

    task automatic test_enable_drop();
        do_reset();
        setup_window(24'd1000, 24'd300);
        for (int i = 0; i < 50; i++) tick();
        en = 1'b0;
        rises = 0; bad_w = 0;
        repeat (30) tick();
        checks++; if (rises != 0) begin errors++; $display("FAIL endrop_pulses: got %0d need 0", rises); end
        checks++; if (bad_w != 0) begin errors++; $display("FAIL endrop_width: got %0d bad need 0", bad_w); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL endrop_active: got %b need 0", active); end
        checks++; if (dut.pcnt !== 24'd0) begin errors++; $display("FAIL endrop_pcnt: got %0d need 0", dut.pcnt); end
        en = 1'b1;
        rises = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (i == 0 || i == 7) begin
                checks++;
                if (dut.pcnt !== 24'(i)) begin errors++; $display("FAIL reen_pcnt i%0d: got %0d need %0d", i, dut.pcnt, i); end
            end
        end
        checks++; if (rises != 30) begin errors++; $display("FAIL reen_count: got %0d need 30", rises); end
    endtask

    task automatic test_shadow_update();
        do_reset();
        setup_window(24'd1000, 24'd300);
        rises = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (i == 500) on_time = 24'd100;
        end
        checks++; if (rises != 30) begin errors++; $display("FAIL shadow_cur: got %0d need 30", rises); end
        rises = 0;
        for (int i = 0; i < 1000; i++) tick();
        checks++; if (rises != 10) begin errors++; $display("FAIL shadow_next: got %0d need 10", rises); end
    endtask

    task automatic test_boundaries();
        int act_seen;
        do_reset();
        setup_window(24'd0, 24'd300);
        act_seen = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (active) act_seen++;
        end
        checks++; if (rises != 0 || act_seen != 0) begin errors++; $display("FAIL period0: got %0d pulses %0d active need 0 0", rises, act_seen); end
        do_reset();
        mode = 1'b1; period = 24'd100; cycles = 8'd0; gen_run = 1'b1; en = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        checks++; if (rises != 0) begin errors++; $display("FAIL cycles0: got %0d need 0", rises); end
        do_reset();
        setup_window(24'd100, 24'd200);
        for (int i = 0; i < 301; i++) tick();
        checks++; if (rises != 30) begin errors++; $display("FAIL full_window: got %0d need 30", rises); end
        checks++; if (bad_w != 0) begin errors++; $display("FAIL full_window_width: got %0d bad need 0", bad_w); end
    endtask

    task automatic test_reset_and_stuck_gen();
        int r, f;
        bit seen;
        do_reset();
        setup_window(24'd1000, 24'd300);
        repeat (150) tick();
        checks++; if (fault_c !== 1'b1) begin errors++; $display("FAIL pre_reset_fault_c: got %b need 1", fault_c); end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (out) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL mid_pulse_wait: got no out pulse need one within 20 clk"); end
        rst = 1'b0;
        tick();
        checks++; if (out !== 1'b0) begin errors++; $display("FAIL rst_mid_out: got %b need 0", out); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL rst_mid_active: got %b need 0", active); end
        checks++; if (fault_c !== 1'b0) begin errors++; $display("FAIL rst_mid_fault_c: got %b need 0", fault_c); end
        rst = 1'b1;
        en = 1'b0;
        tick();
        en = 1'b1;
        r = -1;
        for (int i = 0; i < 50 && r < 0; i++) begin
            tick();
            if (active_c) r = tcount;
        end
        gen_run = 1'b0;
        gen = 1'b1;
        f = -1;
        for (int i = 0; i < 300 && f < 0; i++) begin
            tick();
            if (!active_c) f = tcount;
        end
        checks++; if (r < 0 || f < 0 || f - r != 100) begin errors++; $display("FAIL stuck_gen_clamp: got %0d need 100", f - r); end
        checks++; if (fault_c !== 1'b1) begin errors++; $display("FAIL stuck_gen_fault: got %b need 1", fault_c); end
    endtask

    initial begin
        test_reset();
        test_window_mode();
        test_cycle_mode();
        test_clamp();
        test_enable_drop();
        test_shadow_update();
        test_boundaries();
        test_reset_and_stuck_gen();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
